cr_huf_comp_stcl_sched: RTL

//  Round-robin scheduler sharing one small-table codelength (STCL) builder among NUM_REQ tree requesters.
//  Per job: captures the requester's symbol-depth vector and mode, pulses the builder's start, and steers LUT writes to the owner.

---
 rtl/cr_huf_comp_stcl_sched_pkg.sv | 24 ++
 rtl/cr_huf_comp_rr_arb.sv | 28 ++
 rtl/cr_huf_comp_stcl_sched.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cr_huf_comp_stcl_sched_pkg.sv
// Shared types and widths for the STCL builder scheduler in cr_huf_comp.
package cr_huf_comp_stcl_sched_pkg;

  localparam int STCL_SCHED_MAX_REQ  = 4;
  localparam int HC_HDR_WIDTH        = 64;
  localparam int ST_LUT_ADDR_WIDTH   = 3;
  localparam int STCL_MAX_BITS_WIDTH = 10;
  localparam int HCLEN_WIDTH         = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_RUN,
    ST_DONE,
    ST_ABORT
  } e_stcl_sched_state;

  // Next round-robin position after idx among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cr_huf_comp_rr_arb.sv
// Round-robin arbiter: first active request at or after ptr wins.
module cr_huf_comp_rr_arb #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  // Scan requesters starting at ptr, wrapping, and grant the first one found.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_any && req[(int'(ptr) + i) % N]) begin
        gnt[(int'(ptr) + i) % N] = 1'b1;
        gnt_idx                  = IDX_W'((int'(ptr) + i) % N);
        gnt_any                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cr_huf_comp_stcl_sched.sv
// Shares one STCL builder among NUM_REQ tree requesters: captures the job,
// starts the builder, steers LUT writes to the owner, returns size/HCLEN,
// and drains the builder with read_done when the owner abandons the job.
module cr_huf_comp_stcl_sched
  import cr_huf_comp_stcl_sched_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int MAX_NUM_SYM_USED = 33,
  parameter int CODELENGTH_WIDTH = 4,
  parameter int ABORT_DRAIN_CYC  = 72
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic [NUM_REQ-1:0]                                    req_valid,
  input  logic [NUM_REQ-1:0]                                    req_deflate,
  input  logic [NUM_REQ*MAX_NUM_SYM_USED*CODELENGTH_WIDTH-1:0]  req_sym_dpth,
  input  logic [NUM_REQ-1:0]                                    req_abort,
  output logic [NUM_REQ-1:0]                                    req_ack,
  output logic                                                  bld_start,
  output logic                                                  bld_deflate,
  output logic [MAX_NUM_SYM_USED*CODELENGTH_WIDTH-1:0]          bld_sym_dpth,
  output logic                                                  bld_read_done,
  input  logic                                                  bld_wr,
  input  logic [HC_HDR_WIDTH-1:0]                               bld_wr_data,
  input  logic [ST_LUT_ADDR_WIDTH-1:0]                          bld_wr_addr,
  input  logic                                                  bld_wr_done,
  input  logic [STCL_MAX_BITS_WIDTH-1:0]                        bld_size,
  input  logic [HCLEN_WIDTH-1:0]                                bld_hclen,
  output logic [NUM_REQ-1:0]                                    lut_wr,
  output logic [HC_HDR_WIDTH-1:0]                               lut_wr_data,
  output logic [ST_LUT_ADDR_WIDTH-1:0]                          lut_wr_addr,
  output logic [NUM_REQ-1:0]                                    job_done,
  output logic [STCL_MAX_BITS_WIDTH-1:0]                        job_stcl_size,
  output logic [HCLEN_WIDTH-1:0]                                job_hclen,
  output logic                                                  busy
);

  localparam int DV_W    = MAX_NUM_SYM_USED * CODELENGTH_WIDTH;
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DRAIN_W = $clog2(ABORT_DRAIN_CYC + 1);

  e_stcl_sched_state          state_q, state_d;
  logic [IDX_W-1:0]           owner_q, owner_d;
  logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [DRAIN_W-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]         req_ack_q, req_ack_d;
  logic                       bld_start_q, bld_start_d;
  logic                       bld_deflate_q, bld_deflate_d;
  logic [DV_W-1:0]            bld_sym_dpth_q, bld_sym_dpth_d;
  logic                       bld_read_done_q, bld_read_done_d;
  logic [NUM_REQ-1:0]         lut_wr_q, lut_wr_d;
  logic [HC_HDR_WIDTH-1:0]    lut_wr_data_q, lut_wr_data_d;
  logic [ST_LUT_ADDR_WIDTH-1:0] lut_wr_addr_q, lut_wr_addr_d;
  logic [NUM_REQ-1:0]         job_done_q, job_done_d;
  logic [STCL_MAX_BITS_WIDTH-1:0] job_size_q, job_size_d;
  logic [HCLEN_WIDTH-1:0]     job_hclen_q, job_hclen_d;
  logic                       busy_q, busy_d;

  logic [NUM_REQ-1:0]         gnt;
  logic [IDX_W-1:0]           gnt_idx;
  logic                       gnt_any;
  logic [NUM_REQ-1:0]         owner_oh;

  cr_huf_comp_rr_arb #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign owner_oh = NUM_REQ'(1) << owner_q;

  // Next-state and registered-output computation for the job sequencer.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    rr_ptr_d        = rr_ptr_q;
    cnt_d           = cnt_q;
    req_ack_d       = '0;
    bld_start_d     = 1'b0;
    bld_deflate_d   = bld_deflate_q;
    bld_sym_dpth_d  = bld_sym_dpth_q;
    bld_read_done_d = 1'b0;
    lut_wr_d        = '0;
    lut_wr_data_d   = lut_wr_data_q;
    lut_wr_addr_d   = lut_wr_addr_q;
    job_done_d      = '0;
    job_size_d      = job_size_q;
    job_hclen_d     = job_hclen_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          state_d        = ST_LOAD;
          owner_d        = gnt_idx;
          req_ack_d      = gnt;
          bld_sym_dpth_d = req_sym_dpth[int'(gnt_idx)*DV_W +: DV_W];
          bld_deflate_d  = req_deflate[gnt_idx];
          rr_ptr_d       = IDX_W'(rr_next(int'(gnt_idx), NUM_REQ));
        end
      end
      ST_LOAD: begin
        state_d     = ST_START;
        bld_start_d = 1'b1;
      end
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        // Abort wins over a same-cycle completion; that cycle's write is dropped too.
        if (req_abort[owner_q]) begin
          state_d         = ST_ABORT;
          bld_read_done_d = 1'b1;
          cnt_d           = DRAIN_W'(ABORT_DRAIN_CYC);
        end else begin
          if (bld_wr) begin
            lut_wr_d      = owner_oh;
            lut_wr_data_d = bld_wr_data;
            lut_wr_addr_d = bld_wr_addr;
          end
          if (bld_wr_done) begin
            state_d     = ST_DONE;
            job_done_d  = owner_oh;
            job_size_d  = bld_size;
            job_hclen_d = bld_hclen;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ABORT: begin
        if (cnt_q <= DRAIN_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d           = cnt_q - DRAIN_W'(1);
          bld_read_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset as well so every output is 0 right out of reset.
      state_q         <= ST_IDLE;
      owner_q         <= '0;
      rr_ptr_q        <= '0;
      cnt_q           <= '0;
      req_ack_q       <= '0;
      bld_start_q     <= 1'b0;
      bld_deflate_q   <= 1'b0;
      bld_sym_dpth_q  <= '0;
      bld_read_done_q <= 1'b0;
      lut_wr_q        <= '0;
      lut_wr_data_q   <= '0;
      lut_wr_addr_q   <= '0;
      job_done_q      <= '0;
      job_size_q      <= '0;
      job_hclen_q     <= '0;
      busy_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update together from pre-edge values.
      state_q         <= state_d;
      owner_q         <= owner_d;
      rr_ptr_q        <= rr_ptr_d;
      cnt_q           <= cnt_d;
      req_ack_q       <= req_ack_d;
      bld_start_q     <= bld_start_d;
      bld_deflate_q   <= bld_deflate_d;
      bld_sym_dpth_q  <= bld_sym_dpth_d;
      bld_read_done_q <= bld_read_done_d;
      lut_wr_q        <= lut_wr_d;
      lut_wr_data_q   <= lut_wr_data_d;
      lut_wr_addr_q   <= lut_wr_addr_d;
      job_done_q      <= job_done_d;
      job_size_q      <= job_size_d;
      job_hclen_q     <= job_hclen_d;
      busy_q          <= busy_d;
    end
  end

  assign req_ack       = req_ack_q;
  assign bld_start     = bld_start_q;
  assign bld_deflate   = bld_deflate_q;
  assign bld_sym_dpth  = bld_sym_dpth_q;
  assign bld_read_done = bld_read_done_q;
  assign lut_wr        = lut_wr_q;
  assign lut_wr_data   = lut_wr_data_q;
  assign lut_wr_addr   = lut_wr_addr_q;
  assign job_done      = job_done_q;
  assign job_stcl_size = job_size_q;
  assign job_hclen     = job_hclen_q;
  assign busy          = busy_q;

endmodule
